// File: rtl/network_config.sv
// rtl/network_config.sv - network-wide sizing constants
package network_config;
    localparam int NET_NUM_OUT = 2;
endpackage

// File: rtl/network_run_ctrl.sv
// rtl/network_run_ctrl.sv - steps the network core per commanded timestep and hands each result to the sink
module network_run_ctrl #(
    parameter int RUN_WIDTH = 16,
    parameter int NUM_OUT   = network_config::NET_NUM_OUT,
    parameter int TS_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [RUN_WIDTH-1:0] cmd_runs,
    output logic                 core_step,
    input  logic                 core_done,
    input  logic [NUM_OUT-1:0]   core_out,
    output logic                 net_valid,
    output logic                 net_last,
    input  logic                 net_ready,
    output logic [NUM_OUT-1:0]   net_out,
    output logic                 busy,
    output logic [TS_WIDTH-1:0]  timestep
);

    // One-hot encoding so each state-derived output is a flop bit, never a decode of inputs.
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_STEP = 4'b0010,
        S_WAIT = 4'b0100,
        S_EMIT = 4'b1000
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [RUN_WIDTH-1:0]  r_remaining;
    logic [NUM_OUT-1:0]    r_net_out;
    logic                  r_net_last;
    logic [TS_WIDTH-1:0]   r_timestep;
    logic                  w_cmd_take;
    logic                  w_result_take;
    logic                  w_handshake;

    assign w_cmd_take    = r_state[0] & cmd_valid;
    assign w_result_take = r_state[2] & core_done;
    assign w_handshake   = r_state[3] & net_ready;

    assign cmd_ready = r_state[0];
    assign busy      = ~r_state[0];
    assign core_step = r_state[1];
    assign net_valid = r_state[3];
    assign net_out   = r_net_out;
    assign net_last  = r_net_last;
    assign timestep  = r_timestep;

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: a zero-run command is consumed without leaving IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (cmd_valid && (cmd_runs != '0)) w_next = S_STEP;
            S_STEP: w_next = S_WAIT;
            S_WAIT: if (core_done) w_next = S_EMIT;
            S_EMIT: if (net_ready) w_next = r_net_last ? S_IDLE : S_STEP;
            default: w_next = S_IDLE;
        endcase
    end

    // Run count, captured core result and completed-timestep counter.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_remaining <= '0;
            r_net_out   <= '0;
            r_net_last  <= 1'b0;
            r_timestep  <= '0;
        end else begin
            if (w_cmd_take) begin
                r_remaining <= cmd_runs;
            end
            if (w_result_take) begin
                r_net_out  <= core_out;
                r_net_last <= (r_remaining == RUN_WIDTH'(1));
            end
            if (w_handshake) begin
                r_timestep  <= r_timestep + TS_WIDTH'(1);
                r_remaining <= r_remaining - RUN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_network_run_ctrl.sv
// tb/tb_network_run_ctrl.sv - directed self-checking bench for network_run_ctrl
module tb_network_run_ctrl;

    localparam int RW = 16;
    localparam int NO = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [RW-1:0] cmd_runs;
    logic          core_step;
    logic          core_done;
    logic [NO-1:0] core_out;
    logic          net_valid;
    logic          net_last;
    logic          net_ready;
    logic [NO-1:0] net_out;
    logic          busy;
    logic [TW-1:0] timestep;

    network_run_ctrl #(.RUN_WIDTH(RW), .NUM_OUT(NO), .TS_WIDTH(TW)) dut (
        .clk(clk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_runs(cmd_runs),
        .core_step(core_step), .core_done(core_done), .core_out(core_out),
        .net_valid(net_valid), .net_last(net_last), .net_ready(net_ready),
        .net_out(net_out), .busy(busy), .timestep(timestep)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // core model: answers each step one cycle later with the next queued vector
    logic          model_done = 1'b0;
    logic          spur_done  = 1'b0;
    logic          step_seen  = 1'b0;
    logic          core_auto  = 1'b1;
    logic [NO-1:0] out_q[$];
    assign core_done = model_done | spur_done;

    always @(posedge clk) step_seen <= core_step & core_auto;

    always @(negedge clk) begin
        if (step_seen) begin
            model_done = 1'b1;
            if (out_q.size() > 0) core_out = out_q.pop_front();
            else core_out = '0;
        end else begin
            model_done = 1'b0;
        end
    end

    // sink monitor
    int            n_steps = 0;
    logic [NO-1:0] xfer_out[$];
    logic          xfer_last[$];

    always @(posedge clk) begin
        if (!arst) begin
            if (core_step) n_steps++;
            if (net_valid && net_ready) begin
                xfer_out.push_back(net_out);
                xfer_last.push_back(net_last);
            end
        end
    end

    task automatic issue(input logic [RW-1:0] runs);
        cmd_valid = 1'b1;
        cmd_runs  = runs;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic clear_obs();
        xfer_out.delete();
        xfer_last.delete();
        out_q.delete();
        n_steps = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, core_step, net_valid, net_last, busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/step/val/last/busy=%b want 10000",
                     {cmd_ready, core_step, net_valid, net_last, busy});
        end
        n_checks++;
        if (net_out !== 2'b00 || timestep !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_data: got net_out=%b timestep=%0d want 00 0", net_out, timestep);
        end
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        logic [NO-1:0] exp_out[3];
        logic          exp_last[3];
        exp_out  = '{2'b01, 2'b00, 2'b10};
        exp_last = '{1'b0, 1'b0, 1'b1};
        clear_obs();
        out_q = '{2'b01, 2'b00, 2'b10};
        net_ready = 1'b1;
        issue(3);
        wait_idle(50, cyc);
        n_checks++;
        if (cyc != 9 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_len: got %0d busy cycles after accept (busy=%b) want 9", cyc, busy);
        end
        n_checks++;
        if (n_steps != 3) begin
            n_fail++;
            $display("FAIL basic_steps: got %0d want 3", n_steps);
        end
        n_checks++;
        if (xfer_out.size() != 3) begin
            n_fail++;
            $display("FAIL basic_xfers: got %0d want 3", xfer_out.size());
        end
        for (int i = 0; i < 3 && i < xfer_out.size(); i++) begin
            n_checks++;
            if (xfer_out[i] !== exp_out[i] || xfer_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("FAIL basic_xfer%0d: got out=%b last=%b want out=%b last=%b",
                         i, xfer_out[i], xfer_last[i], exp_out[i], exp_last[i]);
            end
        end
        n_checks++;
        if (timestep !== 4'd3) begin
            n_fail++;
            $display("FAIL basic_timestep: got %0d want 3", timestep);
        end
    endtask

    task automatic test_zero_runs();
        logic saw_busy;
        logic saw_valid;
        clear_obs();
        issue(0);
        saw_busy  = busy;
        saw_valid = net_valid;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            saw_busy  = saw_busy | busy;
            saw_valid = saw_valid | net_valid;
        end
        n_checks++;
        if (saw_busy !== 1'b0 || saw_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_runs_idle: got busy=%b valid=%b ready=%b want 0 0 1", saw_busy, saw_valid, cmd_ready);
        end
        n_checks++;
        if (n_steps != 0 || xfer_out.size() != 0 || timestep !== 4'd3) begin
            n_fail++;
            $display("FAIL zero_runs_activity: got steps=%0d xfers=%0d ts=%0d want 0 0 3",
                     n_steps, xfer_out.size(), timestep);
        end
    endtask

    task automatic test_stall();
        int cyc;
        int steps_at;
        clear_obs();
        out_q = '{2'b10, 2'b11};
        net_ready = 1'b0;
        issue(2);
        cyc = 0;
        while (net_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        steps_at = n_steps;
        n_checks++;
        if (net_valid !== 1'b1 || steps_at != 1) begin
            n_fail++;
            $display("FAIL stall_reach_emit: got valid=%b steps=%0d want 1 1", net_valid, steps_at);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({net_valid, net_out, net_last, core_step} !== 5'b11000 || n_steps != steps_at) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got val/out/last/step=%b steps=%0d want 11000 %0d",
                         i, {net_valid, net_out, net_last, core_step}, n_steps, steps_at);
            end
        end
        net_ready = 1'b1;
        @(negedge clk);
        wait_idle(50, cyc);
        n_checks++;
        if (n_steps != 2 || xfer_out.size() != 2) begin
            n_fail++;
            $display("FAIL stall_counts: got steps=%0d xfers=%0d want 2 2", n_steps, xfer_out.size());
        end
        n_checks++;
        if (xfer_out.size() == 2 &&
            ({xfer_out[0], xfer_last[0], xfer_out[1], xfer_last[1]} !== 6'b100111)) begin
            n_fail++;
            $display("FAIL stall_data: got %b want 100111",
                     {xfer_out[0], xfer_last[0], xfer_out[1], xfer_last[1]});
        end
        n_checks++;
        if (timestep !== 4'd5) begin
            n_fail++;
            $display("FAIL stall_timestep: got %0d want 5", timestep);
        end
    endtask

    task automatic test_spurious_done();
        int cyc;
        clear_obs();
        out_q = '{2'b01, 2'b11};
        net_ready = 1'b1;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || net_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_idle: got busy=%b valid=%b want 0 0", busy, net_valid);
        end
        issue(2);
        cyc = 0;
        while (net_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        wait_idle(50, cyc);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (n_steps != 2 || xfer_out.size() != 2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_counts: got steps=%0d xfers=%0d busy=%b want 2 2 0",
                     n_steps, xfer_out.size(), busy);
        end
        n_checks++;
        if (xfer_out.size() == 2 &&
            ({xfer_out[0], xfer_last[0], xfer_out[1], xfer_last[1]} !== 6'b010111)) begin
            n_fail++;
            $display("FAIL spur_data: got %b want 010111",
                     {xfer_out[0], xfer_last[0], xfer_out[1], xfer_last[1]});
        end
        n_checks++;
        if (timestep !== 4'd7) begin
            n_fail++;
            $display("FAIL spur_timestep: got %0d want 7", timestep);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        clear_obs();
        core_auto = 1'b0;
        net_ready = 1'b1;
        issue(4);
        @(negedge clk);
        n_checks++;
        if ({busy, core_step, net_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid_in_wait: got busy/step/val=%b want 100", {busy, core_step, net_valid});
        end
        core_out  = 2'b11;
        spur_done = 1'b1;
        arst      = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, core_step, net_valid, net_last, busy} !== 5'b10000 ||
            net_out !== 2'b00 || timestep !== 4'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got rdy/step/val/last/busy=%b out=%b ts=%0d want 10000 00 0",
                     {cmd_ready, core_step, net_valid, net_last, busy}, net_out, timestep);
        end
        @(negedge clk);
        @(negedge clk);
        arst      = 1'b0;
        spur_done = 1'b0;
        core_auto = 1'b1;
        @(negedge clk);
        n_checks++;
        if (xfer_out.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_discard: got xfers=%0d busy=%b want 0 0", xfer_out.size(), busy);
        end
        out_q = '{2'b10};
        issue(1);
        wait_idle(50, cyc);
        n_checks++;
        if (cyc != 3 || xfer_out.size() != 1) begin
            n_fail++;
            $display("FAIL rstmid_single: got busy cycles=%0d xfers=%0d want 3 1", cyc, xfer_out.size());
        end
        n_checks++;
        if (xfer_out.size() == 1 && {xfer_out[0], xfer_last[0]} !== 3'b101) begin
            n_fail++;
            $display("FAIL rstmid_data: got out=%b last=%b want 10 1", xfer_out[0], xfer_last[0]);
        end
        n_checks++;
        if (timestep !== 4'd1) begin
            n_fail++;
            $display("FAIL rstmid_timestep: got %0d want 1", timestep);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int n_last;
        clear_obs();
        net_ready = 1'b1;
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            out_q.push_back(2'(i));
            n_checks++;
            if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_ready%0d: got ready=%b busy=%b want 1 0", i, cmd_ready, busy);
            end
            issue(1);
            wait_idle(20, cyc);
            if (i == 15) begin
                n_checks++;
                if (timestep !== 4'd0) begin
                    n_fail++;
                    $display("FAIL b2b_wrap16: got %0d want 0", timestep);
                end
            end
        end
        n_last = 0;
        foreach (xfer_last[i]) if (xfer_last[i] === 1'b1) n_last++;
        n_checks++;
        if (xfer_out.size() != 17 || n_last != 17 || n_steps != 17) begin
            n_fail++;
            $display("FAIL b2b_counts: got xfers=%0d lasts=%0d steps=%0d want 17 17 17",
                     xfer_out.size(), n_last, n_steps);
        end
        n_checks++;
        if (timestep !== 4'd1) begin
            n_fail++;
            $display("FAIL b2b_wrap17: got %0d want 1", timestep);
        end
    endtask

    initial begin
        arst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_runs  = '0;
        net_ready = 1'b0;
        core_out  = '0;
        test_reset();
        test_basic();
        test_zero_runs();
        test_stall();
        test_spurious_done();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, time=%0t", $time);
        $fatal(1);
    end

endmodule
